// File: rtl/seq_learning_neuron_if.sv
// Bus bundle for seq_learning_neuron: operation request, weight load port
// and result outputs. The clock and reset stay outside as plain ports.
//
// Handshake: a request is taken on a rising edge where sln_start=1 and
// sln_ready=1. There is no queue and no backpressure on the outputs.
// sln_axon_valid and sln_change_valid are one-cycle pulses. The data they
// qualify is held after the pulse until the next result.
interface seq_learning_neuron_if #(
  parameter int N_INPUTS = 8,
  parameter int DATA_W   = 16
);
  localparam int ADDR_W = $clog2(N_INPUTS + 1);

  logic                         sln_start;
  logic                         sln_train;
  logic                         sln_ready;
  logic [N_INPUTS*DATA_W-1:0]   sln_dendrites;
  logic [N_INPUTS-1:0]          sln_enabled;
  logic [DATA_W-1:0]            sln_backprop;
  logic [DATA_W-1:0]            sln_training_ratio;
  logic                         sln_wr_en;
  logic [ADDR_W-1:0]            sln_wr_addr;
  logic [DATA_W-1:0]            sln_wr_data;
  logic [DATA_W-1:0]            sln_axon;
  logic                         sln_axon_valid;
  logic [N_INPUTS*DATA_W-1:0]   sln_backprop_change;
  logic                         sln_change_valid;

  modport master (
    output sln_start, sln_train, sln_dendrites, sln_enabled, sln_backprop,
           sln_training_ratio, sln_wr_en, sln_wr_addr, sln_wr_data,
    input  sln_ready, sln_axon, sln_axon_valid, sln_backprop_change,
           sln_change_valid
  );

  modport slave (
    input  sln_start, sln_train, sln_dendrites, sln_enabled, sln_backprop,
           sln_training_ratio, sln_wr_en, sln_wr_addr, sln_wr_data,
    output sln_ready, sln_axon, sln_axon_valid, sln_backprop_change,
           sln_change_valid
  );
endinterface

// File: rtl/seq_learning_neuron.sv
// Time-multiplexed fixed-point learning neuron. The forward pass uses one
// multiplier and handles one lane per cycle. An optional delta-rule update
// then runs, also one lane per cycle, and produces the per-lane backprop
// error for the upstream layer.
module seq_learning_neuron #(
  parameter int N_INPUTS = 8,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int ACC_W    = 40,
  parameter int RELU     = 0
) (
  input  logic                  sln_clock,
  input  logic                  sln_reset,
  seq_learning_neuron_if.slave  bus,
  output logic [2:0]            sln_state_dbg
);

  localparam int ADDR_W = $clog2(N_INPUTS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_OUT   = 3'd2,
    S_DELTA = 3'd3,
    S_UPD   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                      r_state;
  logic [ADDR_W-1:0]           r_idx;
  logic signed [DATA_W-1:0]    r_w [N_INPUTS];
  logic signed [DATA_W-1:0]    r_x [N_INPUTS];
  logic signed [DATA_W-1:0]    r_chg [N_INPUTS];
  logic signed [DATA_W-1:0]    r_bias;
  logic signed [DATA_W-1:0]    r_e;
  logic signed [DATA_W-1:0]    r_lr;
  logic signed [DATA_W-1:0]    r_pre;
  logic signed [DATA_W-1:0]    r_delta;
  logic signed [DATA_W-1:0]    r_axon;
  logic [N_INPUTS-1:0]         r_en;
  logic                        r_train;
  logic                        r_axon_valid;
  logic                        r_change_valid;
  logic signed [ACC_W-1:0]     r_acc;
  logic [N_INPUTS*DATA_W-1:0]  r_bp_out;

  // Sign-extend a data word to accumulator width.
  function automatic logic signed [ACC_W-1:0] ext_dw(input logic signed [DATA_W-1:0] d);
    return {{(ACC_W-DATA_W){d[DATA_W-1]}}, d};
  endfunction

  // Sign-extend a full-width product to accumulator width.
  function automatic logic signed [ACC_W-1:0] ext_p(input logic signed [2*DATA_W-1:0] p);
    return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
  endfunction

  // Clamp an accumulator-width value into the signed data range.
  function automatic logic signed [DATA_W-1:0] sat_w(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = ~hi;
    if (v > hi)      return hi[DATA_W-1:0];
    else if (v < lo) return lo[DATA_W-1:0];
    else             return v[DATA_W-1:0];
  endfunction

  // Drop the fraction bits with floor rounding, then saturate.
  function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] v);
    return sat_w(v >>> FRAC_W);
  endfunction

  logic signed [DATA_W-1:0]    w_cur_w;
  logic signed [DATA_W-1:0]    w_cur_x;
  logic                        w_cur_en;
  logic signed [DATA_W-1:0]    w_mul_a;
  logic signed [DATA_W-1:0]    w_mul_b;
  logic signed [2*DATA_W-1:0]  w_mul_p;
  logic signed [2*DATA_W-1:0]  w_chg_p;
  logic signed [ACC_W-1:0]     w_acc_next;
  logic signed [DATA_W-1:0]    w_pre;
  logic signed [DATA_W-1:0]    w_axon_next;
  logic                        w_gate;
  logic signed [DATA_W-1:0]    w_delta_next;
  logic signed [DATA_W-1:0]    w_chg_cur;
  logic signed [DATA_W-1:0]    w_w_new;
  logic signed [DATA_W-1:0]    w_bias_new;
  logic                        w_last;
  logic [N_INPUTS*DATA_W-1:0]  w_bp_next;

  // Select the lane addressed by the sequencing index.
  always_comb begin
    w_cur_w  = '0;
    w_cur_x  = '0;
    w_cur_en = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (r_idx == ADDR_W'(i)) begin
        w_cur_w  = r_w[i];
        w_cur_x  = r_x[i];
        w_cur_en = r_en[i];
      end
    end
  end

  // The shared multiplier computes x*w in FWD, e*lr in DELTA and delta*x in UPD.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_FWD:   begin w_mul_a = w_cur_x; w_mul_b = w_cur_w; end
      S_DELTA: begin w_mul_a = r_e;     w_mul_b = r_lr;    end
      S_UPD:   begin w_mul_a = r_delta; w_mul_b = w_cur_x; end
      default: begin w_mul_a = '0;      w_mul_b = '0;      end
    endcase
  end

  assign w_mul_p = w_mul_a * w_mul_b;
  assign w_chg_p = r_e * w_cur_w;
  assign w_last  = (r_idx == ADDR_W'(N_INPUTS - 1));

  // Datapath next values for accumulate, activation, delta and update.
  always_comb begin
    w_acc_next   = r_acc + (w_cur_en ? ext_p(w_mul_p) : '0);
    w_pre        = sat_shift(w_acc_next);
    w_axon_next  = ((RELU != 0) && w_pre[DATA_W-1]) ? '0 : w_pre;
    // ReLU with a non-positive pre-activation blocks all learning.
    w_gate       = (RELU != 0) && (r_pre[DATA_W-1] || (r_pre == '0));
    w_delta_next = w_gate ? '0 : sat_shift(ext_p(w_mul_p));
    w_chg_cur    = (w_cur_en && !w_gate) ? sat_shift(ext_p(w_chg_p)) : '0;
    // A masked-off lane has its weight pruned to zero.
    w_w_new      = w_cur_en ? sat_w(ext_dw(w_cur_w) + ext_dw(sat_shift(ext_p(w_mul_p)))) : '0;
    w_bias_new   = sat_w(ext_dw(r_bias) + ext_dw(r_delta));
    w_bp_next    = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      w_bp_next[i*DATA_W +: DATA_W] = (r_idx == ADDR_W'(i)) ? w_chg_cur : r_chg[i];
    end
  end

  // Sequencer FSM with all state, parameters and outputs registered.
  always_ff @(posedge sln_clock) begin
    if (sln_reset) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_bias         <= '0;
      r_e            <= '0;
      r_lr           <= '0;
      r_pre          <= '0;
      r_delta        <= '0;
      r_axon         <= '0;
      r_en           <= '0;
      r_train        <= 1'b0;
      r_axon_valid   <= 1'b0;
      r_change_valid <= 1'b0;
      r_acc          <= '0;
      r_bp_out       <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        r_w[i]   <= '0;
        r_x[i]   <= '0;
        r_chg[i] <= '0;
      end
    end else begin
      r_axon_valid   <= 1'b0;
      r_change_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.sln_start) begin
            for (int i = 0; i < N_INPUTS; i++) begin
              r_x[i] <= $signed(bus.sln_dendrites[i*DATA_W +: DATA_W]);
            end
            r_en    <= bus.sln_enabled;
            r_e     <= $signed(bus.sln_backprop);
            r_lr    <= $signed(bus.sln_training_ratio);
            r_train <= bus.sln_train;
            r_acc   <= ext_dw(r_bias) <<< FRAC_W;
            r_idx   <= '0;
            r_state <= S_FWD;
          end else if (bus.sln_wr_en) begin
            for (int i = 0; i < N_INPUTS; i++) begin
              if (bus.sln_wr_addr == ADDR_W'(i)) r_w[i] <= $signed(bus.sln_wr_data);
            end
            if (bus.sln_wr_addr == ADDR_W'(N_INPUTS)) r_bias <= $signed(bus.sln_wr_data);
          end
        end
        S_FWD: begin
          r_acc <= w_acc_next;
          if (w_last) begin
            r_pre        <= w_pre;
            r_axon       <= w_axon_next;
            r_axon_valid <= 1'b1;
            r_state      <= S_OUT;
          end else begin
            r_idx <= r_idx + ADDR_W'(1);
          end
        end
        S_OUT: begin
          r_state <= r_train ? S_DELTA : S_IDLE;
        end
        S_DELTA: begin
          r_delta <= w_delta_next;
          r_idx   <= '0;
          r_state <= S_UPD;
        end
        S_UPD: begin
          for (int i = 0; i < N_INPUTS; i++) begin
            if (r_idx == ADDR_W'(i)) begin
              r_w[i]   <= w_w_new;
              r_chg[i] <= w_chg_cur;
            end
          end
          if (w_last) begin
            r_bias         <= w_bias_new;
            r_bp_out       <= w_bp_next;
            r_change_valid <= 1'b1;
            r_state        <= S_DONE;
          end else begin
            r_idx <= r_idx + ADDR_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sln_ready           = (r_state == S_IDLE);
  assign bus.sln_axon            = r_axon;
  assign bus.sln_axon_valid      = r_axon_valid;
  assign bus.sln_backprop_change = r_bp_out;
  assign bus.sln_change_valid    = r_change_valid;
  assign sln_state_dbg           = r_state;

endmodule

// File: tb/tb_seq_learning_neuron.sv
// Directed bench for seq_learning_neuron. A linear instance and a ReLU
// instance run side by side on the same stimulus.
module tb_seq_learning_neuron;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = $clog2(N + 1);
  localparam int VW = N * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] st_l;
  logic [2:0] st_r;

  int checks = 0;
  int errors = 0;

  int av_cyc, cv_cyc, rdy_cyc, av_cnt, cv_cnt, av_cnt_r, cv_cnt_r;
  logic [DW-1:0] got_axon, got_axon_r;
  logic [VW-1:0] got_chg, got_chg_r, exp_chg;

  seq_learning_neuron_if #(.N_INPUTS(N), .DATA_W(DW)) bus_l ();
  seq_learning_neuron_if #(.N_INPUTS(N), .DATA_W(DW)) bus_r ();

  seq_learning_neuron #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(8), .ACC_W(40), .RELU(0)) u_lin (
    .sln_clock(clk), .sln_reset(rst), .bus(bus_l), .sln_state_dbg(st_l)
  );

  seq_learning_neuron #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(8), .ACC_W(40), .RELU(1)) u_relu (
    .sln_clock(clk), .sln_reset(rst), .bus(bus_r), .sln_state_dbg(st_r)
  );

  assign bus_r.sln_start          = bus_l.sln_start;
  assign bus_r.sln_train          = bus_l.sln_train;
  assign bus_r.sln_dendrites      = bus_l.sln_dendrites;
  assign bus_r.sln_enabled        = bus_l.sln_enabled;
  assign bus_r.sln_backprop       = bus_l.sln_backprop;
  assign bus_r.sln_training_ratio = bus_l.sln_training_ratio;
  assign bus_r.sln_wr_en          = bus_l.sln_wr_en;
  assign bus_r.sln_wr_addr        = bus_l.sln_wr_addr;
  assign bus_r.sln_wr_data        = bus_l.sln_wr_data;

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rep(input logic [DW-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int addr, input logic [DW-1:0] d);
    bus_l.sln_wr_en   = 1'b1;
    bus_l.sln_wr_addr = AW'(addr);
    bus_l.sln_wr_data = d;
    tick();
    bus_l.sln_wr_en   = 1'b0;
  endtask

  task automatic load_all(input logic [DW-1:0] w, input logic [DW-1:0] b);
    for (int i = 0; i < N; i++) write_w(i, w);
    write_w(N, b);
  endtask

  // Issue one operation and watch it until ready returns (bounded).
  // inj_cyc: cycle at which start+wr_en are pulsed while busy.
  // rst_cyc: cycle at which reset is raised.
  task automatic run_op(input logic tr, input logic [DW-1:0] xv, input logic [N-1:0] m,
                        input logic [DW-1:0] e, input logic [DW-1:0] lr,
                        input int inj_cyc, input int rst_cyc, input logic wr_with_start);
    bus_l.sln_train          = tr;
    bus_l.sln_dendrites      = rep(xv);
    bus_l.sln_enabled        = m;
    bus_l.sln_backprop       = e;
    bus_l.sln_training_ratio = lr;
    bus_l.sln_start          = 1'b1;
    if (wr_with_start) begin
      bus_l.sln_wr_en   = 1'b1;
      bus_l.sln_wr_addr = AW'(N);
      bus_l.sln_wr_data = 16'h7000;
    end
    tick();
    bus_l.sln_start          = 1'b0;
    bus_l.sln_wr_en          = 1'b0;
    bus_l.sln_dendrites      = {$urandom, $urandom, $urandom, $urandom};
    bus_l.sln_enabled        = N'($urandom);
    bus_l.sln_backprop       = DW'($urandom);
    bus_l.sln_training_ratio = DW'($urandom);
    bus_l.sln_train          = 1'($urandom_range(0, 1));
    av_cyc = 0; cv_cyc = 0; rdy_cyc = 0;
    av_cnt = 0; cv_cnt = 0; av_cnt_r = 0; cv_cnt_r = 0;
    got_axon = '0; got_axon_r = '0; got_chg = '0; got_chg_r = '0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (bus_l.sln_axon_valid)   begin av_cnt++; av_cyc = cyc; got_axon = bus_l.sln_axon; end
      if (bus_r.sln_axon_valid)   begin av_cnt_r++; got_axon_r = bus_r.sln_axon; end
      if (bus_l.sln_change_valid) begin cv_cnt++; cv_cyc = cyc; got_chg = bus_l.sln_backprop_change; end
      if (bus_r.sln_change_valid) begin cv_cnt_r++; got_chg_r = bus_r.sln_backprop_change; end
      if (bus_l.sln_ready) begin
        rdy_cyc = cyc;
        break;
      end
      if (cyc == inj_cyc) begin
        bus_l.sln_start   = 1'b1;
        bus_l.sln_wr_en   = 1'b1;
        bus_l.sln_wr_addr = '0;
        bus_l.sln_wr_data = 16'h7FFF;
      end else if (cyc == inj_cyc + 1) begin
        bus_l.sln_start = 1'b0;
        bus_l.sln_wr_en = 1'b0;
      end
      if (cyc == rst_cyc) rst = 1'b1;
      tick();
    end
    bus_l.sln_start = 1'b0;
    bus_l.sln_wr_en = 1'b0;
    rst = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    bus_l.sln_start = 1'b0; bus_l.sln_train = 1'b0; bus_l.sln_dendrites = '0;
    bus_l.sln_enabled = '0; bus_l.sln_backprop = '0; bus_l.sln_training_ratio = '0;
    bus_l.sln_wr_en = 1'b0; bus_l.sln_wr_addr = '0; bus_l.sln_wr_data = '0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_ready", bus_l.sln_ready, 1);
    chk("rst_axon", bus_l.sln_axon, 0);
    chk("rst_axon_valid", bus_l.sln_axon_valid, 0);
    chk("rst_change_valid", bus_l.sln_change_valid, 0);
    chk("rst_change", bus_l.sln_backprop_change, 0);
    chk("rst_state", st_l, 0);
    rst = 1'b0;

    // Default (zero) weights.
    run_op(1'b0, 16'h0100, 8'hFF, 16'h0, 16'h0, 0, 0, 1'b0);
    chk("zero_axon", got_axon, 16'h0000);
    chk("zero_av_cyc", av_cyc, 9);
    chk("zero_rdy_cyc", rdy_cyc, 10);
    chk("zero_av_cnt", av_cnt, 1);
    chk("zero_cv_cnt", cv_cnt, 0);

    // Basic dot product with full and partial masks.
    load_all(16'h0100, 16'h0080);
    run_op(1'b0, 16'h0040, 8'hFF, 16'h0, 16'h0, 0, 0, 1'b0);
    chk("dot_ff", got_axon, 16'h0280);
    chk("dot_ff_relu", got_axon_r, 16'h0280);
    run_op(1'b0, 16'h0040, 8'h0F, 16'h0, 16'h0, 0, 0, 1'b0);
    chk("dot_0f", got_axon, 16'h0180);

    // Saturation in both directions.
    load_all(16'h7FFF, 16'h0080);
    run_op(1'b0, 16'h7FFF, 8'hFF, 16'h0, 16'h0, 0, 0, 1'b0);
    chk("sat_pos", got_axon, 16'h7FFF);
    chk("sat_pos_relu", got_axon_r, 16'h7FFF);
    run_op(1'b0, 16'h8000, 8'hFF, 16'h0, 16'h0, 0, 0, 1'b0);
    chk("sat_neg", got_axon, 16'h8000);
    chk("sat_neg_relu", got_axon_r, 16'h0000);
    run_op(1'b1, 16'h8000, 8'hFF, 16'h0100, 16'h0080, 0, 0, 1'b0);
    chk("neg_train_axon", got_axon, 16'h8000);
    chk("neg_train_cv_cyc", cv_cyc, 19);
    chk("neg_train_chg", got_chg, rep(16'h7FFF));
    chk("neg_train_relu_cv", cv_cnt_r, 1);
    chk("neg_train_relu_chg", got_chg_r, 0);

    // Delta-rule training step with lane 0 masked.
    load_all(16'h0100, 16'h0080);
    exp_chg = rep(16'h0100);
    exp_chg[DW-1:0] = '0;
    run_op(1'b1, 16'h0080, 8'hFE, 16'h0100, 16'h0080, 0, 0, 1'b0);
    chk("train_axon", got_axon, 16'h0400);
    chk("train_av_cyc", av_cyc, 9);
    chk("train_cv_cyc", cv_cyc, 19);
    chk("train_rdy_cyc", rdy_cyc, 20);
    chk("train_cv_cnt", cv_cnt, 1);
    chk("train_chg", got_chg, exp_chg);
    chk("train_chg_relu", got_chg_r, exp_chg);

    // Readback: bias alone, then bias + 7*0x140 weights (w0 pruned).
    run_op(1'b0, 16'h0100, 8'h00, 16'h0, 16'h0, 0, 0, 1'b0);
    chk("rb_bias", got_axon, 16'h0100);
    run_op(1'b0, 16'h0100, 8'hFF, 16'h0, 16'h0, 0, 0, 1'b0);
    chk("rb_weights", got_axon, 16'h09C0);
    chk("rb_chg_held", bus_l.sln_backprop_change, exp_chg);

    // Start and write pulsed while busy are ignored.
    run_op(1'b0, 16'h0100, 8'hFF, 16'h0, 16'h0, 2, 0, 1'b0);
    chk("busy_axon", got_axon, 16'h09C0);
    chk("busy_av_cnt", av_cnt, 1);
    chk("busy_rdy_cyc", rdy_cyc, 10);
    run_op(1'b0, 16'h0100, 8'hFF, 16'h0, 16'h0, 0, 0, 1'b0);
    chk("busy_wr_dropped", got_axon, 16'h09C0);

    // Start wins over a coincident write.
    run_op(1'b0, 16'h0100, 8'h00, 16'h0, 16'h0, 0, 0, 1'b1);
    chk("coinc_axon", got_axon, 16'h0100);
    run_op(1'b0, 16'h0100, 8'h00, 16'h0, 16'h0, 0, 0, 1'b0);
    chk("coinc_wr_dropped", got_axon, 16'h0100);

    // Reset during UPD aborts and clears.
    run_op(1'b1, 16'h0100, 8'hFF, 16'h0100, 16'h0080, 0, 14, 1'b0);
    chk("rstupd_axon_pulse", got_axon, 16'h09C0);
    chk("rstupd_rdy_cyc", rdy_cyc, 15);
    chk("rstupd_cv_cnt", cv_cnt, 0);
    chk("rstupd_axon", bus_l.sln_axon, 0);
    chk("rstupd_chg", bus_l.sln_backprop_change, 0);
    chk("rstupd_state", st_l, 0);
    run_op(1'b0, 16'h0100, 8'hFF, 16'h0, 16'h0, 0, 0, 1'b0);
    chk("rstupd_after", got_axon, 16'h0000);
    chk("rstupd_after_av", av_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
